// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave magnetron controller.
package microwave_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] BCD_DIGIT_MAX    = 4'd9;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] mx);
    return (d > mx) ? mx : d;
  endfunction

  function automatic logic [7:0] clamp_min(input logic [7:0] v);
    return {clamp_digit(v[7:4], BCD_DIGIT_MAX), clamp_digit(v[3:0], BCD_DIGIT_MAX)};
  endfunction

  function automatic logic [7:0] clamp_sec(input logic [7:0] v);
    return {clamp_digit(v[7:4], BCD_SEC_TENS_MAX), clamp_digit(v[3:0], BCD_DIGIT_MAX)};
  endfunction

endpackage

// File: rtl/magnetron_control_if.sv
// Front-panel inputs, latch pulses and display/status outputs of the controller.
interface magnetron_control_if;
  logic       start;
  logic       stop_clear;
  logic       door_closed;
  logic       load;
  logic [7:0] min_in;
  logic [7:0] sec_in;
  logic       S;
  logic       R;
  logic [7:0] min_out;
  logic [7:0] sec_out;
  logic       cooking;
  logic       done;

  modport master (
    output start, stop_clear, door_closed, load, min_in, sec_in,
    input  S, R, min_out, sec_out, cooking, done
  );

  modport slave (
    input  start, stop_clear, door_closed, load, min_in, sec_in,
    output S, R, min_out, sec_out, cooking, done
  );
endinterface

// File: rtl/bcd_mmss_down_counter.sv
// BCD mm:ss register with load and one-second decrement; holds at 00:00.
module bcd_mmss_down_counter
  import microwave_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       dec_i,
  input  logic [7:0] min_ld_i,
  input  logic [7:0] sec_ld_i,
  output logic [7:0] min_o,
  output logic [7:0] sec_o,
  output logic       zero_o
);

  logic [7:0] min_q, sec_q, min_d, sec_d;

  assign zero_o = (min_q == 8'h00) && (sec_q == 8'h00);
  assign min_o  = min_q;
  assign sec_o  = sec_q;

  always_comb begin
    min_d = min_q;
    sec_d = sec_q;
    if (load_i) begin
      min_d = min_ld_i;
      sec_d = sec_ld_i;
    end else if (dec_i && !zero_o) begin
      if (sec_q[3:0] != 4'd0) begin
        sec_d[3:0] = sec_q[3:0] - 4'd1;
      end else if (sec_q[7:4] != 4'd0) begin
        sec_d = {sec_q[7:4] - 4'd1, BCD_DIGIT_MAX};
      end else begin
        // seconds wrap to 59 and borrow one minute
        sec_d = {BCD_SEC_TENS_MAX, BCD_DIGIT_MAX};
        if (min_q[3:0] != 4'd0) min_d[3:0] = min_q[3:0] - 4'd1;
        else                    min_d = {min_q[7:4] - 4'd1, BCD_DIGIT_MAX};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= 8'h00;
      sec_q <= 8'h00;
    end else begin
      min_q <= min_d;
      sec_q <= sec_d;
    end
  end

endmodule

// File: rtl/magnetron_control.sv
// Cook-timer FSM: BCD countdown at 1 Hz, door/start/stop handling, S/R latch pulses.
module magnetron_control
  import microwave_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int DONE_HOLD = 3
) (
  input logic                clk,
  input logic                rst_n,
  magnetron_control_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(DONE_HOLD - 1);

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic [HW-1:0] hold_q;
  logic          s_q, r_q, cooking_q, done_q;

  logic       tick, start_go, idle_go, last_sec, zero;
  logic       cnt_clr, cnt_ld;
  logic [7:0] min_cur, sec_cur;

  assign tick     = (presc_q == PRESC_MAX);
  assign start_go = bus.start && bus.door_closed;
  assign idle_go  = start_go && !zero;
  assign last_sec = (min_cur == 8'h00) && (sec_cur == 8'h01);

  // Counter writes: clear wins over load; both lose to a start that leaves the state.
  always_comb begin
    cnt_clr = 1'b0;
    cnt_ld  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr = !idle_go && bus.stop_clear;
        cnt_ld  = !idle_go && !bus.stop_clear && bus.load;
      end
      PAUSE: begin
        cnt_clr = bus.stop_clear;
        cnt_ld  = !bus.stop_clear && !start_go && bus.load;
      end
      default: ;
    endcase
  end

  bcd_mmss_down_counter u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (cnt_clr || cnt_ld),
    .dec_i    ((state_q == COOK) && tick),
    .min_ld_i (cnt_clr ? 8'h00 : clamp_min(bus.min_in)),
    .sec_ld_i (cnt_clr ? 8'h00 : clamp_sec(bus.sec_in)),
    .min_o    (min_cur),
    .sec_o    (sec_cur),
    .zero_o   (zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      hold_q    <= '0;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      cooking_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      s_q <= 1'b0;
      r_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (idle_go) begin
            state_q   <= COOK;
            s_q       <= 1'b1;
            cooking_q <= 1'b1;
            presc_q   <= '0;
          end
        end
        COOK: begin
          presc_q <= tick ? '0 : presc_q + PW'(1);
          // the final tick takes precedence over a door opening in the same cycle
          if (tick && last_sec) begin
            state_q   <= DONE;
            r_q       <= 1'b1;
            cooking_q <= 1'b0;
            done_q    <= 1'b1;
            presc_q   <= '0;
            hold_q    <= '0;
          end else if (!bus.door_closed || bus.stop_clear) begin
            state_q   <= PAUSE;
            r_q       <= 1'b1;
            cooking_q <= 1'b0;
          end
        end
        PAUSE: begin
          if (bus.stop_clear) begin
            state_q <= IDLE;
          end else if (start_go) begin
            state_q   <= COOK;
            s_q       <= 1'b1;
            cooking_q <= 1'b1;
            presc_q   <= '0;
          end
        end
        DONE: begin
          if (bus.start || bus.stop_clear || !bus.door_closed) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end else if (tick) begin
            presc_q <= '0;
            if (hold_q == HOLD_LAST) begin
              state_q <= IDLE;
              done_q  <= 1'b0;
            end else begin
              hold_q <= hold_q + HW'(1);
            end
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.S       = s_q;
  assign bus.R       = r_q;
  assign bus.min_out = min_cur;
  assign bus.sec_out = sec_cur;
  assign bus.cooking = cooking_q;
  assign bus.done    = done_q;

endmodule
